// File: rtl/uart_pkg.sv
// Shared UART parameters, used by baud_gen_frac, uart_tx and uart_rx.
//   UART_OSR_DEF    : default oversample ticks per bit
//   UART_DIV_W_DEF  : default integer divisor width
//   UART_FRAC_W_DEF : default fractional divisor width
package uart_pkg;
  localparam int UART_OSR_DEF    = 16;
  localparam int UART_DIV_W_DEF  = 16;
  localparam int UART_FRAC_W_DEF = 4;
endpackage

// File: rtl/baud_gen_frac_if.sv
// Control/tick bundle between the baud generator and its users.
//   master : drives en, div_int, div_frac, div_load, sync_clr; receives ticks and div_pending
//   slave  : the generator side
interface baud_gen_frac_if
  import uart_pkg::*;
#(
  parameter int DIV_W  = UART_DIV_W_DEF,
  parameter int FRAC_W = UART_FRAC_W_DEF
) ();
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              sync_clr;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              div_pending;

  modport master (
    output en, div_int, div_frac, div_load, sync_clr,
    input  os_tick, mid_tick, bit_tick, div_pending
  );

  modport slave (
    input  en, div_int, div_frac, div_load, sync_clr,
    output os_tick, mid_tick, bit_tick, div_pending
  );
endinterface

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator for the baud generator.
//   clk, rst_n : clock, async active-low reset
//   adv        : advance acc by act_frac (period wrap)
//   clr        : clear acc (phase re-sync), wins over adv
//   act_frac   : active fractional divisor
//   carry      : carry-out of acc + act_frac; stretches the current period by one clk
module baud_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_W = UART_FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              clr,
  input  logic [FRAC_W-1:0] act_frac,
  output logic              carry
);
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;

  // carry is kept in its own assign so it does not share a process with
  // acc_d, which depends on adv (itself derived from carry)
  assign sum   = {1'b0, acc_q} + {1'b0, act_frac};
  assign carry = sum[FRAC_W];

  always_comb begin
    acc_d = acc_q;
    if (clr)      acc_d = '0;
    else if (adv) acc_d = sum[FRAC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick plus mid-bit and bit-boundary ticks.
// Average os_tick period = act_int + 1 + act_frac/2^FRAC_W clk.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of baud_gen_frac_if (en, divisor load, sync_clr in;
//                os_tick, mid_tick, bit_tick, div_pending out, all registered)
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int DIV_W    = UART_DIV_W_DEF,
  parameter int FRAC_W   = UART_FRAC_W_DEF,
  parameter int OSR      = UART_OSR_DEF,
  parameter int DEF_INT  = 0,
  parameter int DEF_FRAC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  baud_gen_frac_if.slave  bus
);
  localparam int OS_W = $clog2(OSR);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OSR/2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);

  // cnt is one bit wider than the divisor so term = max int + carry fits
  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d, shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d, shd_frac_q, shd_frac_d;
  logic              pend_q, pend_d;
  logic              os_tick_q, os_tick_d;
  logic              mid_tick_q, mid_tick_d;
  logic              bit_tick_q, bit_tick_d;

  logic              carry;
  logic              wrap;
  logic              apply;
  logic [DIV_W:0]    term;

  assign term = {1'b0, act_int_q} + {{DIV_W{1'b0}}, carry};
  assign wrap = bus.en && !bus.sync_clr && (cnt_q == term);

  baud_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (wrap),
    .clr      (bus.sync_clr),
    .act_frac (act_frac_q),
    .carry    (carry)
  );

  // Shadow divisor: a pending value becomes active at the first wrap, en=0
  // or sync_clr. A load in the same clk as a wrap only refills the shadow,
  // so it takes effect one wrap later. A load together with sync_clr skips
  // the shadow and goes straight to the active divisor.
  always_comb begin
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    pend_d     = pend_q;
    apply      = pend_q && (wrap || !bus.en || bus.sync_clr);

    if (apply) begin
      act_int_d  = shd_int_q;
      act_frac_d = shd_frac_q;
      pend_d     = 1'b0;
    end

    if (bus.div_load) begin
      if (bus.sync_clr) begin
        act_int_d  = bus.div_int;
        act_frac_d = bus.div_frac;
        pend_d     = 1'b0;
      end else begin
        shd_int_d  = bus.div_int;
        shd_frac_d = bus.div_frac;
        pend_d     = 1'b1;
      end
    end
  end

  // Period and oversample counters; ticks qualified by pre-increment os_cnt
  always_comb begin
    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    os_tick_d  = wrap;
    mid_tick_d = wrap && (os_cnt_q == OS_MID);
    bit_tick_d = wrap && (os_cnt_q == OS_LAST);

    if (bus.sync_clr) begin
      cnt_d    = '0;
      os_cnt_d = '0;
    end else if (wrap) begin
      cnt_d    = '0;
      os_cnt_d = os_cnt_q + {{(OS_W-1){1'b0}}, 1'b1};
    end else if (bus.en) begin
      cnt_d    = cnt_q + {{DIV_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      act_int_q  <= DIV_W'(DEF_INT);
      act_frac_q <= FRAC_W'(DEF_FRAC);
      shd_int_q  <= '0;
      shd_frac_q <= '0;
      pend_q     <= 1'b0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pend_q     <= pend_d;
      os_tick_q  <= os_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign bus.os_tick     = os_tick_q;
  assign bus.mid_tick    = mid_tick_q;
  assign bus.bit_tick    = bit_tick_q;
  assign bus.div_pending = pend_q;
endmodule
